// File: rtl/ir_transmit.sv
// rtl/ir_transmit.sv - NEC infrared transmitter with mark/space envelope and carrier-gated LED drive
module ir_transmit #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int MODULATE     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rep,
    input  logic [15:0] addr,
    input  logic [7:0]  cmd,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_txd
);

    localparam int CW   = $clog2(UNIT_CYCLES + 1);
    localparam int CARW = $clog2(2 * CARRIER_HALF + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [3:0]        unit_q, unit_d;
    logic [4:0]        bit_q, bit_d;
    logic [31:0]       word_q, word_d;
    logic              rep_q, rep_d;
    logic [CARW-1:0]   car_q, car_d;
    logic              done_q, done_d;

    logic [3:0]        last_unit;
    logic              unit_end;
    logic              mark_d;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        bit_d     = bit_q;
        word_d    = word_q;
        rep_d     = rep_q;
        car_d     = car_q;
        done_d    = 1'b0;
        last_unit = 4'd0;

        case (state_q)
            LEAD_MARK:  last_unit = 4'd15;
            LEAD_SPACE: last_unit = rep_q ? 4'd3 : 4'd7;
            BIT_SPACE:  last_unit = word_q[bit_q] ? 4'd2 : 4'd0;
            default:    last_unit = 4'd0;
        endcase

        unit_end = (cyc_q == CW'(UNIT_CYCLES - 1)) && (unit_q == last_unit);

        if (state_q == IDLE) begin
            if (start) begin
                word_d  = {~cmd, cmd, addr[15:8], addr[7:0]};
                rep_d   = rep;
                state_d = LEAD_MARK;
                cyc_d   = '0;
                unit_d  = '0;
                bit_d   = '0;
            end
        end else begin
            if (cyc_q == CW'(UNIT_CYCLES - 1)) begin
                cyc_d  = '0;
                unit_d = unit_q + 4'd1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
            if (unit_end) begin
                unit_d = '0;
                case (state_q)
                    LEAD_MARK:  state_d = LEAD_SPACE;
                    LEAD_SPACE: state_d = rep_q ? STOP_MARK : BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    BIT_SPACE: begin
                        if (bit_q == 5'd31) begin
                            state_d = STOP_MARK;
                        end else begin
                            state_d = BIT_MARK;
                            bit_d   = bit_q + 5'd1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end

        mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

        // Carrier phase is re-anchored on every mark entry so each mark starts high.
        if (!mark_d || (state_d != state_q)) begin
            car_d = '0;
        end else if (car_q == CARW'(2 * CARRIER_HALF - 1)) begin
            car_d = '0;
        end else begin
            car_d = car_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            rep_q   <= 1'b0;
            car_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            rep_q   <= rep_d;
            car_q   <= car_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign ir_env = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
    assign ir_txd = (MODULATE != 0) ? (ir_env && (car_q < CARW'(CARRIER_HALF))) : ir_env;

endmodule

// File: tb/tb_ir_transmit.sv
// tb/tb_ir_transmit.sv - self-checking bench for ir_transmit against a frame-level NEC model
module tb_ir_transmit;

    localparam int U  = 4;
    localparam int CH = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rep = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  cmd = '0;
    logic        busy, done, ir_env, ir_txd;

    int n_tests = 0;
    int n_fail  = 0;

    ir_transmit #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rep    (rep),
        .addr   (addr),
        .cmd    (cmd),
        .busy   (busy),
        .done   (done),
        .ir_env (ir_env),
        .ir_txd (ir_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Envelope as a list of cycles: NEC timing rules expressed in units.
    task automatic build_model(input logic r, input logic [31:0] w, output bit q[$]);
        q = {};
        repeat (16 * U) q.push_back(1'b1);
        repeat ((r ? 4 : 8) * U) q.push_back(1'b0);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                repeat (U) q.push_back(1'b1);
                repeat ((w[i] ? 3 : 1) * U) q.push_back(1'b0);
            end
        end
        repeat (U) q.push_back(1'b1);
    endtask

    task automatic run_frame(input logic r, input logic [15:0] a, input logic [7:0] c,
                             input bit pre, input int rst_at, input int spur_at);
        bit          q[$];
        bit          cap[$];
        logic [31:0] w;
        logic [31:0] dec;
        int          run;
        int          idx;
        int          ones;
        int          zeros;
        bit          e;
        bit          t;
        w = {~c, c, a[15:8], a[7:0]};
        build_model(r, w, q);
        if (!pre) begin
            @(negedge clk);
            chk("idle_before_start", {30'd0, busy, done}, 32'd0);
            rep = r; addr = a; cmd = c; start = 1'b1;
        end
        run = 0;
        for (int k = 1; k <= q.size(); k++) begin
            @(negedge clk);
            start = (k == spur_at);
            rep   = 1'($urandom);
            addr  = 16'($urandom);
            cmd   = 8'($urandom);
            e = q[k-1];
            if (e) run++; else run = 0;
            t = e && (((run - 1) / CH) % 2 == 0);
            chk($sformatf("frame_cycle_%0d", k), {28'd0, busy, done, ir_env, ir_txd},
                {28'd0, 1'b1, 1'b0, e, t});
            cap.push_back(ir_env);
            if (k == rst_at) begin
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("after_mid_reset", {28'd0, busy, done, ir_env, ir_txd}, 32'd0);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle", {28'd0, busy, done, ir_env, ir_txd}, 32'b0100);
        if (!r) begin
            idx = 0;
            dec = '0;
            while (idx < cap.size() && cap[idx]) idx++;
            while (idx < cap.size() && !cap[idx]) idx++;
            for (int b = 0; b < 32; b++) begin
                ones = 0; zeros = 0;
                while (idx < cap.size() && cap[idx]) begin ones++; idx++; end
                while (idx < cap.size() && !cap[idx]) begin zeros++; idx++; end
                dec[b] = (zeros > 2 * U);
            end
            chk("decoded_word", dec, w);
            chk("decoded_key", {24'd0, dec[23:16]}, {24'd0, c});
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  c;
        logic        r;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, busy, done, ir_env, ir_txd}, 32'd0);
        rst = 1'b0;

        run_frame(1'b0, 16'h0000, 8'h04, 1'b0, 0, 0);
        run_frame(1'b1, 16'($urandom), 8'($urandom), 1'b0, 0, 0);
        run_frame(1'b0, 16'($urandom), 8'($urandom), 1'b0, 0, 50);
        run_frame(1'b0, 16'($urandom), 8'($urandom), 1'b0, 200, 0);

        @(negedge clk);
        rst = 1'b1; start = 1'b1; rep = 1'b0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("reset_beats_start", {28'd0, busy, done, ir_env, ir_txd}, 32'd0);
        @(negedge clk);
        chk("dropped_request", {31'd0, busy}, 32'd0);

        run_frame(1'b0, 16'($urandom), 8'($urandom), 1'b0, 0, 0);
        a = 16'($urandom); c = 8'($urandom);
        rep = 1'b0; addr = a; cmd = c; start = 1'b1;
        run_frame(1'b0, a, c, 1'b1, 0, 0);
        a = 16'($urandom); c = 8'($urandom);
        rep = 1'b1; addr = a; cmd = c; start = 1'b1;
        run_frame(1'b1, a, c, 1'b1, 0, 0);

        for (int i = 0; i < 4; i++) begin
            r = 1'($urandom);
            run_frame(r, 16'($urandom), 8'($urandom), 1'b0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_transmit.md
# ir_transmit

NEC-format infrared transmitter: the sending end of the IR link whose receiver decodes the key byte from bits [23:16] of the 32-bit received word. It takes a 16-bit custom code and an 8-bit key code, or a repeat request, and produces the NEC mark/space envelope and a carrier-modulated drive for an IR LED. It is used for board-to-board control and for loop-back testing of the receive path.

## Interface
- UNIT_CYCLES, 28125: clk cycles per NEC time unit (562.5 us at 50 MHz).
- CARRIER_HALF, 658: clk cycles per carrier half-period (~38 kHz at 50 MHz).
- MODULATE, 1: 1 = `ir_txd` is the gated carrier; 0 = `ir_txd` equals `ir_env`.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request; sampled only while `busy`=0.
- rep  in  1  sampled with `start`: 1 = send a repeat code, 0 = send a full frame.
- addr  in  16  custom code; sampled with `start`.
- cmd  in  8  key code; sampled with `start`.
- busy  out  1  high while a frame or repeat code is in progress.
- done  out  1  one-cycle pulse when transmission completes.
- ir_env  out  1  unmodulated envelope; 1 = mark (carrier on).
- ir_txd  out  1  LED drive.

## Operation
- Reset values: `busy`=0, `done`=0, `ir_env`=0, `ir_txd`=0, FSM=IDLE, all counters 0.
- On accepted `start`, latch the frame word W = {~cmd, cmd, addr[15:8], addr[7:0]}. Bits are sent W[0] first, W[31] last, which places `cmd` in received bits [23:16].
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- Full frame sequence:
  - LEAD_MARK: 16 units.
  - LEAD_SPACE: 8 units.
  - For each bit i = 0..31: BIT_MARK for 1 unit, then BIT_SPACE for 1 unit if W[i]=0 or 3 units if W[i]=1.
  - STOP_MARK: 1 unit, then IDLE.
- Repeat code sequence: LEAD_MARK 16 units, LEAD_SPACE 4 units, STOP_MARK 1 unit, then IDLE. Bit states are skipped and `addr`/`cmd` are ignored.
- Counters:
  - Cycle counter runs 0..UNIT_CYCLES-1.
  - Unit counter counts units within the current state.
  - Bit index counts 0..31 and moves to STOP_MARK after bit 31's space.
- `ir_env`=1 exactly in the mark states, 0 otherwise.
- Carrier:
  - The carrier counter restarts at 0 on the first cycle of every mark.
  - Carrier is high for CARRIER_HALF cycles, then low for CARRIER_HALF cycles, repeating.
  - `ir_txd` = `ir_env` AND carrier when MODULATE=1.
  - In a space, `ir_txd` is always 0.
- `start` while `busy`=1 is ignored; it is not queued. Inter-frame spacing (the NEC 108 ms period) is the caller's responsibility.
- `rst` asserted mid-frame: all outputs return to reset values on the next edge, with no stop mark. `rst` together with `start`: reset wins and the request is dropped.

## Timing
- `start` accepted at edge n: `busy`=1, `ir_env`=1, `ir_txd`=1 (MODULATE=1) from cycle n+1. Latency is one cycle.
- Each state lasts exactly k*UNIT_CYCLES cycles, with no gap cycles between states.
- Full frame length: 24 + 2*Z + 4*O + 1 units, where Z and O are the counts of 0 and 1 bits in W.
- Repeat code length: 21 units.
- The last transmitting cycle is n+L, where L is the length in cycles. At n+L+1: `busy`=0, `ir_env`=0, `done`=1 for exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high. Back-to-back frames therefore have exactly one idle cycle between them.

## Test plan
- UNIT_CYCLES=4, CARRIER_HALF=1, addr=16'h0000, cmd=8'h04, rep=0, start at n:
  - `ir_env` high for cycles n+1..n+64, low for n+65..n+96.
  - W has 8 ones and 24 zeros, so L=105 units = 420 cycles; `done` pulses at n+421.
  - The captured `ir_env` edges decode back to a 32-bit word with [23:16]=8'h04 and [31:24]=8'hFB.
- Same parameters, rep=1: mark 64 cycles, space 16, mark 4; `done` at n+85; `addr`/`cmd` changes during the code have no effect.
- MODULATE=1, CARRIER_HALF=1: within every mark `ir_txd` toggles 1,0,1,0 starting high on the mark's first cycle. In every space `ir_txd`=0.
- `start` pulsed at n+50 during a frame: no effect; frame length and `done` time are unchanged.
- `rst` at n+200 mid-bit: the next cycle has `busy`=`ir_env`=`ir_txd`=`done`=0. A subsequent `start` produces a full, correct frame.
- `start` asserted in the cycle `done`=1: the second frame's lead mark begins on the following cycle; end-to-end loop-back through the receiver yields the second `cmd`.
